shell_mode_ctrl: RTL and testbench

//  Sits between the UART RX deserializer and the rest of ice40_picorv32_top.
//  In SHELL mode it assembles received bytes into a command line and executes
//  the 's' command, which switches the system to APP mode.
//  It owns app_mode and cpu_resetn. In APP mode it forwards RX bytes to the
//  CPU UART, and returns to SHELL mode when the CPU requests it.

---
 rtl/shell_mode_ctrl_pkg.sv | 22 ++
 rtl/shell_mode_ctrl_if.sv | 24 ++
 rtl/shell_line_buffer.sv | 45 ++++
 rtl/shell_mode_ctrl.sv | 151 +++++++++++++++
 tb/tb_shell_mode_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/shell_mode_ctrl_pkg.sv
// Shared state encodings and ASCII constants for the shell/app mode controller.
package shell_ctrl_pkg;

  typedef logic [2:0] shell_state_t;

  localparam shell_state_t SH_IDLE  = 3'd0;
  localparam shell_state_t SH_LINE  = 3'd1;
  localparam shell_state_t SH_EXEC  = 3'd2;
  localparam shell_state_t APP_HOLD = 3'd3;
  localparam shell_state_t APP_RUN  = 3'd4;

  localparam logic [7:0] CHR_CR  = 8'h0D;
  localparam logic [7:0] CHR_LF  = 8'h0A;
  localparam logic [7:0] CHR_BS  = 8'h08;
  localparam logic [7:0] CHR_DEL = 8'h7F;
  localparam logic [7:0] CHR_S   = 8'h73;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/shell_mode_ctrl_if.sv
// Byte/control bundle between the UART front end, the CPU side and shell_mode_ctrl.
interface shell_mode_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       cpu_shell_req;
  logic       app_mode;
  logic       cpu_resetn;
  logic       app_rx_valid;
  logic [7:0] app_rx_data;
  logic       cmd_error;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output rx_valid, rx_data, cpu_shell_req, tx_ready,
    input  app_mode, cpu_resetn, app_rx_valid, app_rx_data, cmd_error, tx_valid, tx_data
  );

  modport slave (
    input  rx_valid, rx_data, cpu_shell_req, tx_ready,
    output app_mode, cpu_resetn, app_rx_valid, app_rx_data, cmd_error, tx_valid, tx_data
  );
endinterface

// File: rtl/shell_line_buffer.sv
// Command line storage: byte count, overflow flag and backspace handling.
module shell_line_buffer #(
  parameter int unsigned LINE_MAX = 16,
  localparam int unsigned CW = $clog2(LINE_MAX + 1),
  localparam int unsigned IW = $clog2(LINE_MAX)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic [CW-1:0] cnt,
  output logic [7:0]    byte0,
  output logic          ovf
);

  logic [7:0] mem [LINE_MAX];

  assign full  = (cnt == CW'(LINE_MAX));
  assign byte0 = mem[0];

  // Contents are never reset: cnt==0 is what marks the line empty.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[cnt[IW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (push) begin
      if (full) ovf <= 1'b1;
      else      cnt <= cnt + CW'(1);
    end else if (pop && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/shell_mode_ctrl.sv
// SHELL/APP mode controller: line assembly, 's' command, CPU reset hold, RX forwarding.
// Optional byte echo to UART TX when SHELL_ECHO_EN is defined.
module shell_mode_ctrl
  import shell_ctrl_pkg::*;
#(
  parameter int unsigned LINE_MAX = 16,
  parameter int unsigned RST_HOLD = 16
) (
  input  logic                clk,
  input  logic                resetn,
  shell_mode_ctrl_if.slave    bus
);

  localparam int unsigned CW = $clog2(LINE_MAX + 1);
  localparam int unsigned HW = $clog2(RST_HOLD);

  shell_state_t  state;
  logic [HW-1:0] hold_cnt;
  logic          app_mode_q, cpu_resetn_q, app_rx_valid_q, cmd_error_q;
  logic [7:0]    app_rx_data_q;

  logic          lb_full, lb_ovf;
  logic [CW-1:0] lb_cnt;
  logic [7:0]    lb_byte0;

  logic accepting, rx_print, rx_eol, rx_bs, shell_req, exec_ok;
  logic lb_push, lb_pop, lb_clear;

  always_comb begin
    accepting = (state == SH_IDLE) || (state == SH_LINE);
    rx_print  = bus.rx_valid && is_printable(bus.rx_data);
    rx_eol    = bus.rx_valid && ((bus.rx_data == CHR_CR) || (bus.rx_data == CHR_LF));
    rx_bs     = bus.rx_valid && ((bus.rx_data == CHR_BS) || (bus.rx_data == CHR_DEL));
    shell_req = bus.cpu_shell_req && ((state == APP_HOLD) || (state == APP_RUN));
    exec_ok   = !lb_ovf && (lb_cnt == CW'(1)) && (lb_byte0 == CHR_S);
    lb_push   = accepting && rx_print;
    lb_pop    = accepting && rx_bs;
    lb_clear  = (state == SH_EXEC) || shell_req || (accepting && rx_eol && (lb_cnt == '0));
  end

  shell_line_buffer #(.LINE_MAX(LINE_MAX)) u_line (
    .clk    (clk),
    .resetn (resetn),
    .push   (lb_push),
    .din    (bus.rx_data),
    .pop    (lb_pop),
    .clear  (lb_clear),
    .full   (lb_full),
    .cnt    (lb_cnt),
    .byte0  (lb_byte0),
    .ovf    (lb_ovf)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= SH_IDLE;
      hold_cnt       <= '0;
      app_mode_q     <= 1'b0;
      cpu_resetn_q   <= 1'b0;
      app_rx_valid_q <= 1'b0;
      app_rx_data_q  <= '0;
      cmd_error_q    <= 1'b0;
    end else begin
      app_rx_valid_q <= 1'b0;
      cmd_error_q    <= 1'b0;
      case (state)
        SH_IDLE, SH_LINE: begin
          if (rx_print)
            state <= SH_LINE;
          else if (rx_eol)
            state <= (lb_cnt == '0) ? SH_IDLE : SH_EXEC;
        end
        SH_EXEC: begin
          if (exec_ok) begin
            app_mode_q <= 1'b1;
            hold_cnt   <= HW'(RST_HOLD - 1);
            state      <= APP_HOLD;
          end else begin
            cmd_error_q <= 1'b1;
            state       <= SH_IDLE;
          end
        end
        APP_HOLD: begin
          if (hold_cnt == '0) begin
            cpu_resetn_q <= 1'b1;
            state        <= APP_RUN;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        APP_RUN: begin
          if (bus.rx_valid) begin
            app_rx_valid_q <= 1'b1;
            app_rx_data_q  <= bus.rx_data;
          end
        end
        default: state <= SH_IDLE;
      endcase
      // Placed after the case so a shell request overrides the hold/run
      // transitions while the same-cycle forwarded byte still goes out.
      if (shell_req) begin
        app_mode_q   <= 1'b0;
        cpu_resetn_q <= 1'b0;
        state        <= SH_IDLE;
      end
    end
  end

  assign bus.app_mode     = app_mode_q;
  assign bus.cpu_resetn   = cpu_resetn_q;
  assign bus.app_rx_valid = app_rx_valid_q;
  assign bus.app_rx_data  = app_rx_data_q;
  assign bus.cmd_error    = cmd_error_q;

`ifdef SHELL_ECHO_EN
  logic       tx_valid_q;
  logic [7:0] tx_data_q;
  logic       lf_pend;

  // A CR or LF is echoed as CR then LF; the LF is queued behind the CR handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      lf_pend    <= 1'b0;
    end else if (tx_valid_q) begin
      if (bus.tx_ready) begin
        if (lf_pend) begin
          tx_data_q <= CHR_LF;
          lf_pend   <= 1'b0;
        end else begin
          tx_valid_q <= 1'b0;
        end
      end
    end else if (accepting && ((rx_print && !lb_full) || rx_eol)) begin
      tx_valid_q <= 1'b1;
      tx_data_q  <= rx_eol ? CHR_CR : bus.rx_data;
      lf_pend    <= rx_eol;
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
`else
  logic tx_ready_unused;
  assign tx_ready_unused = bus.tx_ready;
  assign bus.tx_valid    = 1'b0;
  assign bus.tx_data     = '0;
`endif

endmodule

// File: tb/tb_shell_mode_ctrl.sv
// Scoreboard bench for shell_mode_ctrl: expected forwards, errors and echoes are queued
// when stimulus is driven and matched as the DUT emits them.
module tb_shell_mode_ctrl;
  localparam int unsigned LINE_MAX = 16;
  localparam int unsigned RST_HOLD = 16;

  logic clk = 1'b0;
  logic resetn;
  int   n_checks = 0;
  int   n_errors = 0;
  logic echo_chk = 1'b0;

  logic [7:0] fwd_q[$];
  logic       err_q[$];
  logic [7:0] echo_q[$];

  always #5 clk = ~clk;

  shell_mode_ctrl_if bus();

  shell_mode_ctrl #(.LINE_MAX(LINE_MAX), .RST_HOLD(RST_HOLD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Called right after the line terminator was sampled; checks mode-switch latency and hold length.
  task automatic wait_app();
    int i = 0;
    int n = 0;
    while (!bus.app_mode && i < 4) begin
      @(negedge clk);
      i++;
    end
    chk("app_lat", {31'd0, (bus.app_mode && i <= 2)}, 1);
    while (!bus.cpu_resetn && n < 100) begin
      bus.rx_valid = (n == 3);
      bus.rx_data  = 8'h55;
      @(negedge clk);
      n++;
    end
    bus.rx_valid = 1'b0;
    chk("hold_len", n, RST_HOLD);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (bus.app_rx_valid) begin
      if (fwd_q.size() == 0) chk("fwd_unexp", {31'd0, bus.app_rx_valid}, 0);
      else                   chk("fwd_data", {24'd0, bus.app_rx_data}, {24'd0, fwd_q.pop_front()});
    end
    if (bus.cmd_error) begin
      if (err_q.size() == 0) chk("err_unexp", {31'd0, bus.cmd_error}, 0);
      else                   chk("cmd_err", {31'd0, bus.cmd_error}, {31'd0, err_q.pop_front()});
    end
    if (echo_chk && bus.tx_valid && bus.tx_ready) begin
      if (echo_q.size() == 0) chk("echo_unexp", {31'd0, bus.tx_valid}, 0);
      else                    chk("echo_data", {24'd0, bus.tx_data}, {24'd0, echo_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.cpu_shell_req = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_app_mode", {31'd0, bus.app_mode}, 0);
    chk("rst_cpu_resetn", {31'd0, bus.cpu_resetn}, 0);
    chk("rst_app_rx_valid", {31'd0, bus.app_rx_valid}, 0);
    chk("rst_cmd_error", {31'd0, bus.cmd_error}, 0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Shell request in shell mode is ignored; an empty line raises no error.
    bus.cpu_shell_req = 1'b1;
    @(negedge clk);
    bus.cpu_shell_req = 1'b0;
    send_byte(8'h0A, 3);
    chk("shell_req_ign", {31'd0, bus.app_mode}, 0);

    err_q.push_back(1'b1);
    send_byte("x", 2);
    send_byte(8'h0A, 4);
    chk("bad_cmd_mode", {31'd0, bus.app_mode}, 0);

    // Overflow flag alone must reject a line trimmed back to a single 's'.
    err_q.push_back(1'b1);
    for (int unsigned k = 0; k < LINE_MAX + 1; k++) send_byte("s", 2);
    for (int unsigned k = 0; k < LINE_MAX - 1; k++) send_byte(8'h08, 2);
    send_byte(8'h0A, 4);
    chk("ovf_mode", {31'd0, bus.app_mode}, 0);

    send_byte("s", 2);
    send_byte("x", 2);
    send_byte(8'h7F, 2);
    send_byte(8'h0A, 0);
    wait_app();

    fwd_q.push_back(8'h31);
    send_byte(8'h31, 2);
    fwd_q.push_back("s");
    send_byte("s", 2);
    chk("app_stays", {31'd0, bus.app_mode}, 1);

    fwd_q.push_back(8'h74);
    bus.rx_valid = 1'b1;
    bus.rx_data = 8'h74;
    bus.cpu_shell_req = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.cpu_shell_req = 1'b0;
    chk("ret_app_mode", {31'd0, bus.app_mode}, 0);
    chk("ret_cpu_resetn", {31'd0, bus.cpu_resetn}, 0);
    repeat (2) @(negedge clk);

    send_byte("s", 2);
    send_byte(8'h0D, 0);
    wait_app();

    bus.cpu_shell_req = 1'b1;
    @(negedge clk);
    bus.cpu_shell_req = 1'b0;
    repeat (2) @(negedge clk);
    send_byte("s", 2);
    send_byte(8'h0A, 0);
    repeat (5) @(negedge clk);
    chk("hold_mode", {31'd0, bus.app_mode}, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_mode", {31'd0, bus.app_mode}, 0);
    chk("mid_rst_cpu", {31'd0, bus.cpu_resetn}, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (RST_HOLD + 4) @(negedge clk);
    chk("post_rst_cpu", {31'd0, bus.cpu_resetn}, 0);

`ifdef SHELL_ECHO_EN
    bus.tx_ready = 1'b0;
    echo_chk = 1'b1;
    send_byte("a", 2);
    send_byte("b", 2);
    chk("echo_hold_v", {31'd0, bus.tx_valid}, 1);
    chk("echo_hold_d", {24'd0, bus.tx_data}, {24'd0, 8'h61});
    echo_q.push_back("a");
    bus.tx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("echo_drop_b", {31'd0, bus.tx_valid}, 0);
    echo_q.push_back(8'h0D);
    echo_q.push_back(8'h0A);
    err_q.push_back(1'b1);
    send_byte(8'h0D, 5);
`else
    chk("tx_tied", {23'd0, bus.tx_valid, bus.tx_data}, 0);
`endif

    repeat (5) @(negedge clk);
    chk("fwd_q_empty", fwd_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    chk("echo_q_empty", echo_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
